// File: rtl/spi_slave_cmd_seq_if.sv
// Bus bundle between the SPI command sequencer, the RX/TX shifters and the
// register file / AXI bridge side. The sequencer uses the slave view.
interface spi_slave_cmd_seq_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 4
);
  localparam int RSW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic                  cs;
  logic                  sdi;
  logic                  sdo;
  logic [7:0]            dummy_cycles;
  logic [DATA_WIDTH-1:0] tx_data;
  logic [7:0]            cmd;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  tx_req;
  logic                  reg_we;
  logic                  reg_re;
  logic                  mem_we;
  logic                  mem_re;
  logic [RSW-1:0]        reg_sel;
  logic                  error;

  modport slave (
    input  cs, sdi, dummy_cycles, tx_data,
    output sdo, cmd, addr, rx_data, rx_valid, tx_req,
           reg_we, reg_re, mem_we, mem_re, reg_sel, error
  );

  modport master (
    output cs, sdi, dummy_cycles, tx_data,
    input  sdo, cmd, addr, rx_data, rx_valid, tx_req,
           reg_we, reg_re, mem_we, mem_re, reg_sel, error
  );
endinterface

// File: rtl/spi_slave_cmd_seq.sv
// SPI slave command sequencer: shifts in the command byte, decodes it and
// walks the transaction through address, dummy and data phases, issuing
// per-word strobes with address auto-increment for memory bursts.
module spi_slave_cmd_seq #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 4
) (
  input logic                sclk,
  input logic                sys_rstn,
  spi_slave_cmd_seq_if.slave bus
);
  localparam int RSW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  // One input shifter serves command, address and RX data phases.
  localparam int SW   = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  // Counter must hold the longest phase, including 255 dummy bits.
  localparam int CMAX = (SW > 256) ? SW : 256;
  localparam int CW   = $clog2(CMAX);

  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [CW-1:0]         CNT_CMD   = CW'(7);
  localparam logic [CW-1:0]         CNT_ADDR  = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0]         CNT_DATA  = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_CMD, S_ADDR, S_DUMMY, S_RX, S_TX, S_DONE, S_ERR
  } state_t;

  typedef enum logic [1:0] {K_ILL, K_REGW, K_REGR, K_MEM} kind_t;

  state_t                state_reg, state_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [SW-2:0]         sh_reg, sh_next;
  logic [DATA_WIDTH-1:0] tx_sh_reg, tx_sh_next;
  logic [7:0]            cmd_reg, cmd_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] rx_data_reg, rx_data_next;
  logic                  rx_valid_reg, rx_valid_next;
  logic                  reg_we_reg, reg_we_next;
  logic                  mem_we_reg, mem_we_next;
  logic [RSW-1:0]        reg_sel_reg, reg_sel_next;
  logic                  error_reg, error_next;

  logic [SW-1:0]         in_word;
  logic                  last_bit;
  logic                  mem_mode;
  kind_t                 dec_kind;
  logic [3:0]            dec_idx;
  logic                  tx_req_c, reg_re_c, mem_re_c;
  logic [ADDR_WIDTH-1:0] addr_out;
  logic [RSW-1:0]        reg_sel_out;

  // Word as it will look after this edge: lets the last bit of a phase be used directly.
  assign in_word  = {sh_reg, bus.sdi};
  assign last_bit = (cnt_reg == '0);
  assign mem_mode = (cmd_reg == 8'h02) || (cmd_reg == 8'h03) || (cmd_reg == 8'h0B);

  // Command decoder over the byte completed by the current sdi bit.
  always_comb begin
    dec_kind = K_ILL;
    dec_idx  = 4'd0;
    case (in_word[7:0])
      8'h01: begin dec_kind = K_REGW; dec_idx = 4'd0; end
      8'h11: begin dec_kind = K_REGW; dec_idx = 4'd1; end
      8'h20: begin dec_kind = K_REGW; dec_idx = 4'd2; end
      8'h30: begin dec_kind = K_REGW; dec_idx = 4'd3; end
      8'h05: begin dec_kind = K_REGR; dec_idx = 4'd0; end
      8'h07: begin dec_kind = K_REGR; dec_idx = 4'd1; end
      8'h21: begin dec_kind = K_REGR; dec_idx = 4'd2; end
      8'h31: begin dec_kind = K_REGR; dec_idx = 4'd3; end
      8'h02, 8'h03, 8'h0B: dec_kind = K_MEM;
      default: begin
        if (in_word[7:4] == 4'h4) begin
          dec_kind = K_REGW;
          dec_idx  = in_word[3:0];
        end else if (in_word[7:4] == 4'h8) begin
          dec_kind = K_REGR;
          dec_idx  = in_word[3:0];
        end
      end
    endcase
    if ((dec_kind == K_REGW || dec_kind == K_REGR) && (int'(dec_idx) >= NUM_REGS)) begin
      dec_kind = K_ILL;
    end
  end

  // Next-state, datapath updates and the early (final-bit) TX request strobes.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = last_bit ? cnt_reg : cnt_reg - CW'(1);
    sh_next       = in_word[SW-2:0];
    tx_sh_next    = {tx_sh_reg[DATA_WIDTH-2:0], 1'b0};
    cmd_next      = cmd_reg;
    addr_next     = addr_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = 1'b0;
    reg_we_next   = 1'b0;
    mem_we_next   = 1'b0;
    reg_sel_next  = reg_sel_reg;
    error_next    = error_reg;
    tx_req_c      = 1'b0;
    reg_re_c      = 1'b0;
    mem_re_c      = 1'b0;
    addr_out      = addr_reg;
    reg_sel_out   = reg_sel_reg;

    // Burst write: step the address once the accepted word has been strobed out.
    if (mem_we_reg) addr_next = addr_reg + ADDR_STEP;

    case (state_reg)
      S_CMD: begin
        if (last_bit) begin
          cmd_next = in_word[7:0];
          case (dec_kind)
            K_REGW: begin
              state_next   = S_RX;
              cnt_next     = CNT_DATA;
              reg_sel_next = dec_idx[RSW-1:0];
            end
            K_REGR: begin
              tx_req_c     = 1'b1;
              reg_re_c     = 1'b1;
              reg_sel_out  = dec_idx[RSW-1:0];
              reg_sel_next = dec_idx[RSW-1:0];
              tx_sh_next   = bus.tx_data;
              state_next   = S_TX;
              cnt_next     = CNT_DATA;
            end
            K_MEM: begin
              state_next = S_ADDR;
              cnt_next   = CNT_ADDR;
            end
            default: begin
              state_next = S_ERR;
              error_next = 1'b1;
            end
          endcase
        end
      end
      S_ADDR: begin
        if (last_bit) begin
          // Present the completed address while any first-word request is up.
          addr_out  = in_word[ADDR_WIDTH-1:0];
          addr_next = in_word[ADDR_WIDTH-1:0];
          if (cmd_reg == 8'h02) begin
            state_next = S_RX;
            cnt_next   = CNT_DATA;
          end else if (cmd_reg == 8'h0B && bus.dummy_cycles != 8'd0) begin
            state_next = S_DUMMY;
            cnt_next   = CW'(bus.dummy_cycles) - CW'(1);
          end else begin
            tx_req_c   = 1'b1;
            mem_re_c   = 1'b1;
            tx_sh_next = bus.tx_data;
            addr_next  = in_word[ADDR_WIDTH-1:0] + ADDR_STEP;
            state_next = S_TX;
            cnt_next   = CNT_DATA;
          end
        end
      end
      S_DUMMY: begin
        if (last_bit) begin
          tx_req_c   = 1'b1;
          mem_re_c   = 1'b1;
          tx_sh_next = bus.tx_data;
          addr_next  = addr_reg + ADDR_STEP;
          state_next = S_TX;
          cnt_next   = CNT_DATA;
        end
      end
      S_RX: begin
        if (last_bit) begin
          rx_data_next  = in_word[DATA_WIDTH-1:0];
          rx_valid_next = 1'b1;
          if (mem_mode) begin
            mem_we_next = 1'b1;
            cnt_next    = CNT_DATA;
          end else begin
            reg_we_next = 1'b1;
            state_next  = S_DONE;
          end
        end
      end
      S_TX: begin
        if (last_bit) begin
          if (mem_mode) begin
            tx_req_c   = 1'b1;
            mem_re_c   = 1'b1;
            tx_sh_next = bus.tx_data;
            addr_next  = addr_reg + ADDR_STEP;
            cnt_next   = CNT_DATA;
          end else begin
            tx_sh_next = '0;
            state_next = S_DONE;
          end
        end
      end
      default: begin
        // DONE / ERR: park with a quiet line until the master deselects.
        sh_next    = sh_reg;
        tx_sh_next = '0;
      end
    endcase

    // Deselect wins over everything registered; a strobe already up still completes.
    if (bus.cs) begin
      state_next    = S_CMD;
      cnt_next      = CNT_CMD;
      sh_next       = '0;
      tx_sh_next    = '0;
      error_next    = 1'b0;
      cmd_next      = cmd_reg;
      addr_next     = addr_reg;
      rx_data_next  = rx_data_reg;
      reg_sel_next  = reg_sel_reg;
      rx_valid_next = 1'b0;
      reg_we_next   = 1'b0;
      mem_we_next   = 1'b0;
    end
  end

  // FSM state and phase bit counter.
  always_ff @(posedge sclk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_reg <= S_CMD;
      cnt_reg   <= CNT_CMD;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Shifters, captured fields and registered RX strobes.
  always_ff @(posedge sclk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      sh_reg       <= '0;
      tx_sh_reg    <= '0;
      cmd_reg      <= '0;
      addr_reg     <= '0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
      reg_we_reg   <= 1'b0;
      mem_we_reg   <= 1'b0;
      reg_sel_reg  <= '0;
      error_reg    <= 1'b0;
    end else begin
      sh_reg       <= sh_next;
      tx_sh_reg    <= tx_sh_next;
      cmd_reg      <= cmd_next;
      addr_reg     <= addr_next;
      rx_data_reg  <= rx_data_next;
      rx_valid_reg <= rx_valid_next;
      reg_we_reg   <= reg_we_next;
      mem_we_reg   <= mem_we_next;
      reg_sel_reg  <= reg_sel_next;
      error_reg    <= error_next;
    end
  end

  assign bus.sdo      = tx_sh_reg[DATA_WIDTH-1];
  assign bus.cmd      = cmd_reg;
  assign bus.addr     = addr_out;
  assign bus.rx_data  = rx_data_reg;
  assign bus.rx_valid = rx_valid_reg;
  assign bus.tx_req   = tx_req_c;
  assign bus.reg_we   = reg_we_reg;
  assign bus.reg_re   = reg_re_c;
  assign bus.mem_we   = mem_we_reg;
  assign bus.mem_re   = mem_re_c;
  assign bus.reg_sel  = reg_sel_out;
  assign bus.error    = error_reg;
endmodule

// File: doc/spi_slave_cmd_seq.md
# spi_slave_cmd_seq

Parametrised SPI slave command sequencer that succeeds the fixed combinational command decoder. It shifts the serial command byte in itself, decodes it, and then walks the transaction through address, dummy and data phases with bit counters. Per-word strobes go to the register file and the AXI bridge, with address auto-increment for memory bursts. It runs in the `sclk` domain between the SPI RX/TX shifters and the clock-domain-crossing FIFOs.

## Interface
- `ADDR_WIDTH`, 32: address phase length in bits; valid range 8..32.
- `DATA_WIDTH`, 32: data word length in bits; multiple of 8.
- `NUM_REGS`, 4: number of slave registers; valid range 1..16. `RSW = max(1, $clog2(NUM_REGS))`.
- `sclk` in 1: SPI clock; all state changes on the rising edge.
- `sys_rstn` in 1: reset, asynchronous, active-low.
- `cs` in 1: chip select, active-high deselect, sampled synchronously.
- `sdi` in 1: serial data in, MSB first.
- `sdo` out 1: serial data out, equal to the TX shift register MSB.
- `dummy_cycles` in 8: dummy bits for a memory read, sampled at the end of the address phase.
- `tx_data` in DATA_WIDTH: word to transmit; sampled on the edge after `tx_req`.
- `cmd` out 8: last decoded command.
- `addr` out ADDR_WIDTH: current word address.
- `rx_data` out DATA_WIDTH: last received word.
- `rx_valid`, `tx_req` out 1: one-cycle strobes.
- `reg_we`, `reg_re`, `mem_we`, `mem_re` out 1: one-cycle strobes qualifying `rx_valid` or `tx_req`.
- `reg_sel` out RSW: selected register.
- `error` out 1: illegal command; held until `cs` goes high.

## Operation
- FSM states: CMD, ADDR, DUMMY, RX, TX, DONE, ERR. Bit counter `cnt` counts down to 0 within each phase.
- `cs`=1 at any edge: go to CMD with `cnt`=7. This clears `error` and the shift registers; `addr` and `cmd` hold their values. No strobes are issued.
- CMD: 8 bits shifted in. On the 8th bit the command is decoded into the next state, and `cmd` is updated on the same edge.
- Legacy command codes:
  - 0x01/0x11/0x20/0x30: write reg0..3.
  - 0x05/0x07/0x21/0x31: read reg0..3.
  - 0x02: write mem (continuous).
  - 0x0B: read mem (continuous, dummy phase).
- Generalised command codes:
  - 0x40|r: write reg r.
  - 0x80|r: read reg r.
  - 0x03: read mem (continuous, no dummy phase).
- Register command codes with r ≥ NUM_REGS are illegal. Any other code is illegal: the FSM enters ERR and `error` goes to 1 on the decode edge.
- Next state after decode:
  - Register write: RX.
  - Register read: TX.
  - Memory command: ADDR.
- ADDR: ADDR_WIDTH bits into `addr`.
  - After 0x02, go to RX.
  - After 0x03, go to TX.
  - After 0x0B, go to DUMMY, or directly to TX if `dummy_cycles`=0.
- DUMMY: `dummy_cycles` bits ignored, then TX.
- RX: DATA_WIDTH bits. On the last bit, `rx_data` is updated and `rx_valid` is pulsed on the following cycle, together with `reg_we` or `mem_we`.
  - Register command: go to DONE.
  - Memory command: stay in RX, and `addr` += DATA_WIDTH/8 on the edge after `rx_valid`.
- TX:
  - `tx_req` (with `reg_re`/`mem_re`) is asserted during the final bit of the preceding phase.
  - On the phase-boundary edge the TX shift register loads `tx_data`, so `sdo` presents bit DATA_WIDTH-1 on the first TX bit.
  - In memory mode, `tx_req` repeats on the last bit of each word and `addr` increments on the word-boundary edge.
  - Register read: go to DONE after one word.
- DONE/ERR: ignore `sdi`, `sdo`=0, no strobes until `cs`.
- Address increment wraps modulo 2^ADDR_WIDTH.

## Timing
- Reset values: all outputs 0 (`sdo`, `cmd`, `addr`, `rx_data`, `reg_sel`, every strobe, `error`); state CMD, `cnt`=7.
- Reset asserted mid-transfer: immediate return to reset values, with no partial strobes.
- `rx_valid` latency: 1 cycle after the last data bit edge.
- `tx_req` lead: exactly 1 cycle before the TX shift register load.
- Strobes are single-cycle and never overlap: `rx_valid`/`tx_req` and their qualifiers only.
- `cs` high on the same edge as a final data bit: the word is discarded and no strobe is issued.
- `cs` high in the cycle a strobe is already asserted: that strobe still completes, since it was registered earlier.
- First bit after `cs` falls is bit 7 of the command.

## Test plan
- Register write: reset, `cs`=0, cmd 0x11, then 0xDEADBEEF → `reg_we`=1, `reg_sel`=1, `rx_data`=0xDEADBEEF one cycle after bit 40. Further bits produce no strobes.
- Memory read with dummy: cmd 0x0B, addr 0x00001000, `dummy_cycles`=8, `tx_data`=0xA5A5A5A5 → `tx_req`+`mem_re` at bit 48, `sdo` shifts 0xA5A5A5A5 over bits 49..80.
  - Second `tx_req` at bit 80 with `addr`=0x00001004.
- Burst write wrap: cmd 0x02, addr 0xFFFFFFFC, two words → `mem_we` twice; `addr` 0xFFFFFFFC, then 0x00000000.
- Illegal command: cmd 0x84 with NUM_REGS=4 → `error`=1 from bit 8 until `cs`=1, no strobes.
  - A following cmd 0x05 works normally, with `error`=0.
- Abort: `cs`=1 at bit 20 of a 0x02 transaction → no strobes. Next transaction cmd 0x40 writes reg 0 correctly.
- Reset mid-TX: `sys_rstn` low during a 0x03 data phase → all outputs 0 immediately, next command decoded from bit 1.
